// File: rtl/case_1_div_pkg.sv
// Shared FSM state type and default operand widths for the sequential signed divider.
package case_1_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIN0_WIDTH = 7;
  localparam int DIN1_WIDTH = 6;
  localparam int DOUT_WIDTH = 7;

endpackage

// File: rtl/case_1_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module case_1_div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] trial;
  logic [W:0] diff;

  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - {1'b0, divisor};
    q_bit   = (trial >= {1'b0, divisor});
    rem_out = q_bit ? W'(diff) : W'(trial);
  end

endmodule

// File: rtl/case_1_sdiv_7s_6s_7_seq.sv
// Sequential signed divider (truncating), one quotient bit per cycle with valid/ready handshakes.
// Optional div_by_zero output port is enabled by defining CASE_1_SDIV_DBZ_FLAG_EN.
module case_1_sdiv_7s_6s_7_seq
  import case_1_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_WIDTH,
  parameter int din1_WIDTH = DIN1_WIDTH,
  parameter int dout_WIDTH = DOUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem
`ifdef CASE_1_SDIV_DBZ_FLAG_EN
  ,
  output logic                  div_by_zero
`endif
);

  localparam int unsigned MW = ((din0_WIDTH > din1_WIDTH) ? din0_WIDTH : din1_WIDTH) + 1;
  localparam int unsigned CW = $clog2(din0_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(din0_WIDTH);

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q;
  logic [MW-1:0]         num_q;
  logic [MW-1:0]         part_q;
  logic [MW-1:0]         den_q;
  logic [din0_WIDTH-1:0] raw_q;
  logic                  neg_q_q;
  logic                  neg_r_q;
  logic                  dbz_q;
  logic [dout_WIDTH-1:0] dout_q;
  logic [din1_WIDTH-1:0] rem_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic [MW-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [MW-1:0] q_signed, r_signed;
  logic [MW-1:0] part_nx;
  logic          q_bit;
  logic          accept;

  always_comb begin
    a_ext    = {{(MW-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
    b_ext    = {{(MW-din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
    a_mag    = din0[din0_WIDTH-1] ? (~a_ext + MW'(1)) : a_ext;
    b_mag    = din1[din1_WIDTH-1] ? (~b_ext + MW'(1)) : b_ext;
    q_signed = neg_q_q ? (~num_q + MW'(1)) : num_q;
    r_signed = neg_r_q ? (~part_q + MW'(1)) : part_q;
  end

  // Dividend is left-aligned so the step always consumes num_q's MSB; the zero fill
  // shifted in behind it leaves the quotient magnitude occupying all of num_q at the end.
  case_1_div_step #(.W(MW)) u_step (
    .rem_in  (part_q),
    .bit_in  (num_q[MW-1]),
    .divisor (den_q),
    .rem_out (part_nx),
    .q_bit   (q_bit)
  );

  assign accept = (state_q == IDLE) && in_ready_q && in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      part_q      <= '0;
      den_q       <= '0;
      raw_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      dbz_q       <= 1'b0;
      dout_q      <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            num_q   <= a_mag << (MW - din0_WIDTH);
            part_q  <= '0;
            den_q   <= b_mag;
            raw_q   <= din0;
            neg_q_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            neg_r_q <= din0[din0_WIDTH-1];
            dbz_q   <= (din1 == '0);
          end
        end
        CALC: begin
          if (cnt_q == LAST) begin
            if (dbz_q) begin
              dout_q <= '1;
              rem_q  <= din1_WIDTH'(raw_q);
            end else begin
              dout_q <= dout_WIDTH'(q_signed);
              rem_q  <= din1_WIDTH'(r_signed);
            end
          end else begin
            num_q  <= {num_q[MW-2:0], q_bit};
            part_q <= part_nx;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign rem       = rem_q;

`ifdef CASE_1_SDIV_DBZ_FLAG_EN
  assign div_by_zero = dbz_q;
`endif

endmodule

// File: doc/case_1_sdiv_7s_6s_7_seq.md
CASE_1_SDIV_7S_6S_7_SEQ -- requirements
Module: case_1_sdiv_7s_6s_7_seq

Interface
REQ-001 SHALL have parameter ID, default 1: instance identifier with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 7: signed dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 6: signed divisor width and remainder width.
REQ-004 SHALL have parameter dout_WIDTH, default 7: signed quotient output width.
REQ-005 SHALL have port ap_clk  in  1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port ap_rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  in  1: operands presented.
REQ-008 SHALL have port in_ready  out  1: block can accept operands.
REQ-009 SHALL have port din0  in  din0_WIDTH: signed dividend.
REQ-010 SHALL have port din1  in  din1_WIDTH: signed divisor.
REQ-011 SHALL have port out_valid  out  1: result available.
REQ-012 SHALL have port out_ready  in  1: consumer accepts the result.
REQ-013 SHALL have port dout  out  dout_WIDTH: signed quotient.
REQ-014 SHALL have port rem  out  din1_WIDTH: signed remainder.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE with in_valid=1, register both operands, operand signs, and absolute values, then go to CALC.
REQ-017 SHALL, in CALC, perform one restoring shift-subtract step per cycle on unsigned magnitudes for exactly din0_WIDTH cycles, then go to DONE.
REQ-018 SHALL assert out_valid exactly din0_WIDTH+1 cycles after the accepting edge (8 cycles at the defaults).
REQ-019 SHALL hold dout and rem stable in DONE until out_valid&&out_ready; on that edge go to IDLE with no bubble requirement beyond one IDLE cycle.
REQ-020 SHALL use truncating semantics: quotient sign = sign(din0) XOR sign(din1); remainder sign = sign(din0); dout = low dout_WIDTH bits of the quotient.
REQ-021 SHALL compute magnitudes at din0_WIDTH+1 bits so that |-2^(din0_WIDTH-1)| is exact.
REQ-022 SHALL, for overflow case din0=-2^(din0_WIDTH-1), din1=-1, return wrapped quotient -2^(din0_WIDTH-1) and rem=0.
REQ-023 SHALL, for din1=0, skip the iterations' effect and return dout = all ones (-1) and rem = low din1_WIDTH bits of din0, at the same latency as REQ-018.
REQ-024 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.

Reset
REQ-025 SHALL, while ap_rst_n=0, force state IDLE, in_ready=0, out_valid=0, dout=0, rem=0, and all internal registers to 0, independent of ap_clk.
REQ-026 SHALL assert in_ready=1 on the first edge after ap_rst_n deasserts; reset during CALC or DONE aborts the operation and discards its result.

Configuration
REQ-027 SHALL, with CASE_1_SDIV_DBZ_FLAG_EN defined, add output port div_by_zero (1 bit), valid with out_valid, equal to 1 if the accepted din1 was 0, and reset to 0.
REQ-028 SHALL, without CASE_1_SDIV_DBZ_FLAG_EN, omit the div_by_zero port; all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state typedef (IDLE/CALC/DONE) and default width constants in package case_1_div_pkg.
REQ-030 SHALL implement one combinational restoring step (partial remainder, divisor -> next partial remainder, quotient bit) as sub-module case_1_div_step, instantiated once.

Verification
REQ-031 SHALL cover: din0=45, din1=7 -> dout=6, rem=3, out_valid exactly 8 cycles after accept.
REQ-032 SHALL cover: din0=-45, din1=7 -> dout=-6, rem=-3; din0=45, din1=-7 -> dout=-6, rem=3.
REQ-033 SHALL cover: din0=-64, din1=-1 -> dout=-64 (7'h40), rem=0.
REQ-034 SHALL cover: din0=17, din1=0 -> dout=7'h7F, rem=17, div_by_zero=1 when the macro is defined.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> dout, rem, and out_valid stable, in_ready=0, new in_valid ignored.
REQ-036 SHALL cover: ap_rst_n pulsed low mid-CALC -> out_valid never asserts for that operation and in_ready=1 one edge after release.
